config_sequencer: RTL and testbench

- Power-up configuration sequencer that drives `delay_generator` through `en_delay` and consumes its `delay_done` pulses.
- Walks a command table of register writes and timed waits, and issues each write to the downstream serial register writer over a req/ack handshake.
- Signals `config_done` once the table is exhausted; the capture/detection datapath is released on `config_done`.

---
 rtl/config_sequencer_if.sv | 25 ++
 rtl/config_sequencer.sv | 127 ++++++++++++
 tb/tb_config_sequencer.sv | 531 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/config_sequencer_if.sv
// Register-writer request/acknowledge bundle.
// The sequencer holds req/addr/data until the writer pulses ack.
interface config_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;

  modport master (
    output wr_req,
    output wr_addr,
    output wr_data,
    input  wr_ack
  );

  modport slave (
    input  wr_req,
    input  wr_addr,
    input  wr_data,
    output wr_ack
  );
endinterface

// File: rtl/config_sequencer.sv
// Power-up configuration sequencer: walks a table of
// register writes and timed waits, then raises config_done.
module config_sequencer #(
  parameter int NUM_ENTRIES = 16,
  parameter int IDX_W       = 4,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  output logic [IDX_W-1:0]         rom_index,
  input  logic [1+ADDR_W+DATA_W:0] rom_entry,
  output logic                     en_delay,
  input  logic                     delay_done,
  config_sequencer_if.master       wr,
  output logic                     busy,
  output logic                     config_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WRITE,
    S_DELAY,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_DELAY = 2'b01;
  localparam logic [1:0] OP_END   = 2'b10;

  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(NUM_ENTRIES - 1);

  state_t            state;
  logic [DATA_W-1:0] dly_cnt;
  logic [DATA_W-1:0] dly_tgt;

  logic [1:0]        f_op;
  logic [ADDR_W-1:0] f_addr;
  logic [DATA_W-1:0] f_data;

  assign f_op   = rom_entry[1+ADDR_W+DATA_W -: 2];
  assign f_addr = rom_entry[DATA_W +: ADDR_W];
  assign f_data = rom_entry[DATA_W-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      rom_index   <= '0;
      en_delay    <= 1'b0;
      wr.wr_req   <= 1'b0;
      wr.wr_addr  <= '0;
      wr.wr_data  <= '0;
      busy        <= 1'b0;
      config_done <= 1'b0;
      dly_cnt     <= '0;
      dly_tgt     <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state       <= S_FETCH;
            rom_index   <= '0;
            busy        <= 1'b1;
            config_done <= 1'b0;
          end
        end
        S_FETCH: begin
          unique case (f_op)
            OP_WRITE: begin
              state      <= S_WRITE;
              wr.wr_addr <= f_addr;
              wr.wr_data <= f_data;
            end
            OP_DELAY: begin
              state    <= S_DELAY;
              en_delay <= 1'b1;
              dly_cnt  <= '0;
              // A zero count still waits one unit.
              dly_tgt  <= (f_data == '0) ?
                          DATA_W'(1) : f_data;
            end
            OP_END: begin
              state       <= S_DONE;
              busy        <= 1'b0;
              config_done <= 1'b1;
            end
            default: state <= S_NEXT;
          endcase
        end
        S_WRITE: begin
          if (!wr.wr_req) begin
            wr.wr_req <= 1'b1;
          end else if (wr.wr_ack) begin
            wr.wr_req <= 1'b0;
            state     <= S_NEXT;
          end
        end
        S_DELAY: begin
          if (delay_done) begin
            if (dly_cnt == dly_tgt - DATA_W'(1)) begin
              en_delay <= 1'b0;
              state    <= S_NEXT;
            end else begin
              dly_cnt <= dly_cnt + DATA_W'(1);
            end
          end
        end
        S_NEXT: begin
          if (rom_index == LAST) begin
            state       <= S_DONE;
            busy        <= 1'b0;
            config_done <= 1'b1;
          end else begin
            rom_index <= rom_index + IDX_W'(1);
            state     <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_config_sequencer.sv
// Bench for config_sequencer: writer and delay-generator
// models, table-level reference model, random tables.
module tb_config_sequencer;

  localparam int NUM   = 16;
  localparam int DLY_P = 7;
  localparam logic [1:0] OW = 2'd0;
  localparam logic [1:0] OD = 2'd1;
  localparam logic [1:0] OE = 2'd2;
  localparam logic [1:0] ON = 2'd3;

  logic        clock = 0;
  logic        reset = 1;
  logic        start = 0;
  logic [3:0]  rom_index;
  logic [17:0] rom_entry;
  logic        en_delay;
  logic        delay_done;
  logic        busy;
  logic        config_done;

  logic [17:0] rom [NUM];
  assign rom_entry = rom[rom_index];

  config_sequencer_if #(.ADDR_W(8), .DATA_W(8)) wr ();

  logic dd_model  = 0;
  logic dd_man    = 0;
  logic ack_model = 0;
  logic ack_man   = 0;
  bit   auto_ack  = 0;
  bit   clr_mon   = 0;
  assign delay_done = dd_model | dd_man;
  assign wr.wr_ack  = ack_model | ack_man;

  config_sequencer #(
    .NUM_ENTRIES(NUM), .IDX_W(4),
    .ADDR_W(8), .DATA_W(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .rom_index(rom_index),
    .rom_entry(rom_entry),
    .en_delay(en_delay),
    .delay_done(delay_done),
    .wr(wr.master),
    .busy(busy),
    .config_done(config_done)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // monitor: {delays completed, addr, data} per write
  logic [23:0] obs_wr[$];
  int          obs_dly[$];
  int          pulse_cnt = 0;
  int          unstable = 0;
  int          bad_fall = 0;
  logic        prev_en = 0;
  logic        prev_req = 0;
  logic [15:0] prev_ad = 0;
  int          dcnt = 0;
  int          acnt = 0;

  always @(negedge clock) begin
    if (clr_mon) begin
      obs_wr.delete();
      obs_dly.delete();
      pulse_cnt = 0;
      unstable  = 0;
      bad_fall  = 0;
    end else begin
      if (prev_en && dd_model) pulse_cnt++;
      if (prev_en && !en_delay) begin
        if (!dd_model) bad_fall++;
        obs_dly.push_back(pulse_cnt);
        pulse_cnt = 0;
      end
      if (wr.wr_req && !prev_req)
        obs_wr.push_back({8'(obs_dly.size()),
                          wr.wr_addr, wr.wr_data});
      if (wr.wr_req && prev_req &&
          {wr.wr_addr, wr.wr_data} !== prev_ad)
        unstable++;
    end
    prev_en  = en_delay;
    prev_req = wr.wr_req;
    prev_ad  = {wr.wr_addr, wr.wr_data};
    if (en_delay) begin
      dcnt++;
      if (dcnt == DLY_P) begin
        dd_model = 1;
        dcnt = 0;
      end else begin
        dd_model = 0;
      end
    end else begin
      dcnt = 0;
      dd_model = 0;
    end
    if (ack_model) begin
      ack_model = 0;
    end else if (auto_ack && wr.wr_req) begin
      if (acnt == 0) begin
        ack_model = 1;
        acnt = $urandom_range(0, 4);
      end else begin
        acnt--;
      end
    end
  end

  logic [23:0] exp_wr[$];
  int          exp_dly[$];
  int          exp_last;

  function automatic logic [17:0] mk(
    logic [1:0] op, logic [7:0] a, logic [7:0] d);
    return {op, a, d};
  endfunction

  task automatic tick(int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic clear_mon();
    clr_mon = 1;
    tick(2);
    clr_mon = 0;
  endtask

  task automatic fill(logic [1:0] op);
    for (int i = 0; i < NUM; i++) rom[i] = mk(op, 0, 0);
  endtask

  // Table-level meaning of the program, no timing.
  task automatic build_expect();
    int nd;
    exp_wr.delete();
    exp_dly.delete();
    exp_last = NUM - 1;
    nd = 0;
    for (int i = 0; i < NUM; i++) begin
      logic [1:0] op;
      op = rom[i][17:16];
      if (op == OE) begin
        exp_last = i;
        break;
      end
      if (op == OW)
        exp_wr.push_back({8'(nd), rom[i][15:0]});
      if (op == OD) begin
        exp_dly.push_back(rom[i][7:0] == 0 ?
                          1 : int'(rom[i][7:0]));
        nd++;
      end
    end
  endtask

  task automatic run_and_check(string name);
    int  k;
    bit  ok;
    build_expect();
    clear_mon();
    auto_ack = 1;
    start = 1;
    tick(1);
    start = 0;
    n_cmp++;
    if (config_done !== 0 || busy !== 1 ||
        rom_index !== 0) begin
      n_bad++;
      $display("FAIL %s start: done=%b busy=%b idx=%0d want 0/1/0",
               name, config_done, busy, rom_index);
    end
    k = 0;
    while (config_done !== 1 && k < 3000) begin
      tick(1);
      k++;
    end
    n_cmp++;
    if (config_done !== 1) begin
      n_bad++;
      $display("FAIL %s timeout: config_done=%b want 1",
               name, config_done);
    end
    tick(2);
    n_cmp++;
    if (rom_index !== 4'(exp_last)) begin
      n_bad++;
      $display("FAIL %s last_index: got %0d want %0d",
               name, rom_index, exp_last);
    end
    ok = (obs_wr.size() == exp_wr.size());
    if (ok)
      foreach (exp_wr[i])
        if (obs_wr[i] !== exp_wr[i]) ok = 0;
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s writes: got %p want %p",
               name, obs_wr, exp_wr);
    end
    ok = (obs_dly.size() == exp_dly.size());
    if (ok)
      foreach (exp_dly[i])
        if (obs_dly[i] != exp_dly[i]) ok = 0;
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s delays: got %p want %p",
               name, obs_dly, exp_dly);
    end
    n_cmp++;
    if (unstable != 0 || bad_fall != 0) begin
      n_bad++;
      $display("FAIL %s protocol: unstable=%0d bad_fall=%0d want 0/0",
               name, unstable, bad_fall);
    end
    n_cmp++;
    if (busy !== 0 || en_delay !== 0 ||
        wr.wr_req !== 0) begin
      n_bad++;
      $display("FAIL %s idle_outs: busy=%b en=%b req=%b want 0",
               name, busy, en_delay, wr.wr_req);
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({rom_index, en_delay, wr.wr_req, wr.wr_addr,
         wr.wr_data, busy, config_done} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got %0h want 0",
               {rom_index, en_delay, wr.wr_req, wr.wr_addr,
                wr.wr_data, busy, config_done});
    end
    reset = 1;
    start = 1;
    tick(1);
    start = 0;
    n_cmp++;
    if (busy !== 0 || rom_index !== 0) begin
      n_bad++;
      $display("FAIL reset_vs_start: busy=%b idx=%0d want 0/0",
               busy, rom_index);
    end
    reset = 0;
    tick(2);
    n_cmp++;
    if (busy !== 0 || config_done !== 0) begin
      n_bad++;
      $display("FAIL reset_vs_start_after: busy=%b done=%b want 0/0",
               busy, config_done);
    end
  endtask

  task automatic test_basic_write();
    fill(ON);
    rom[0] = mk(OW, 8'h12, 8'h80);
    rom[1] = mk(OE, 0, 0);
    auto_ack = 0;
    start = 1;
    tick(1);
    start = 0;
    n_cmp++;
    if (busy !== 1 || rom_index !== 0) begin
      n_bad++;
      $display("FAIL bw_c1: busy=%b idx=%0d want 1/0",
               busy, rom_index);
    end
    tick(1);
    n_cmp++;
    if (wr.wr_req !== 0) begin
      n_bad++;
      $display("FAIL bw_c2: wr_req=%b want 0", wr.wr_req);
    end
    tick(1);
    n_cmp++;
    if (wr.wr_req !== 1 || wr.wr_addr !== 8'h12 ||
        wr.wr_data !== 8'h80) begin
      n_bad++;
      $display("FAIL bw_c3: req=%b addr=%h data=%h want 1/12/80",
               wr.wr_req, wr.wr_addr, wr.wr_data);
    end
    tick(3);
    n_cmp++;
    if (wr.wr_req !== 1) begin
      n_bad++;
      $display("FAIL bw_c6: wr_req=%b want 1", wr.wr_req);
    end
    ack_man = 1;
    tick(1);
    ack_man = 0;
    n_cmp++;
    if (wr.wr_req !== 0) begin
      n_bad++;
      $display("FAIL bw_c7: wr_req=%b want 0", wr.wr_req);
    end
    tick(1);
    n_cmp++;
    if (config_done !== 0) begin
      n_bad++;
      $display("FAIL bw_c8: config_done=%b want 0", config_done);
    end
    tick(1);
    n_cmp++;
    if (config_done !== 1 || busy !== 0) begin
      n_bad++;
      $display("FAIL bw_c9: done=%b busy=%b want 1/0",
               config_done, busy);
    end
  endtask

  task automatic test_delay3();
    fill(ON);
    rom[0] = mk(OD, 0, 8'd3);
    rom[1] = mk(OE, 0, 0);
    run_and_check("delay3");
  endtask

  task automatic test_back_to_back();
    fill(ON);
    rom[0] = mk(OD, 0, 8'd0);
    rom[1] = mk(OD, 0, 8'd1);
    rom[2] = mk(OW, 8'h11, 8'h01);
    rom[3] = mk(OE, 0, 0);
    run_and_check("b2b");
  endtask

  task automatic test_nop_full();
    int prev;
    int bad_steps;
    int k;
    fill(ON);
    start = 1;
    tick(1);
    start = 0;
    prev = 0;
    bad_steps = 0;
    k = 0;
    while (config_done !== 1 && k < 200) begin
      tick(1);
      k++;
      if (int'(rom_index) != prev) begin
        if (int'(rom_index) != prev + 1) bad_steps++;
        prev = rom_index;
      end
    end
    n_cmp++;
    if (config_done !== 1 || bad_steps != 0 ||
        prev != NUM - 1) begin
      n_bad++;
      $display("FAIL nop_walk: done=%b bad=%0d last=%0d want 1/0/15",
               config_done, bad_steps, prev);
    end
    tick(5);
    n_cmp++;
    if (rom_index !== 4'd15 || config_done !== 1) begin
      n_bad++;
      $display("FAIL nop_nowrap: idx=%0d done=%b want 15/1",
               rom_index, config_done);
    end
  endtask

  task automatic test_reset_abort();
    int k;
    fill(ON);
    rom[0] = mk(OD, 0, 8'd200);
    rom[1] = mk(OE, 0, 0);
    start = 1;
    tick(1);
    start = 0;
    k = 0;
    while (en_delay !== 1 && k < 20) begin
      tick(1);
      k++;
    end
    tick(3);
    n_cmp++;
    if (en_delay !== 1) begin
      n_bad++;
      $display("FAIL abort_dly_pre: en_delay=%b want 1", en_delay);
    end
    reset = 1;
    tick(1);
    reset = 0;
    n_cmp++;
    if ({rom_index, en_delay, wr.wr_req, wr.wr_addr,
         wr.wr_data, busy, config_done} !== '0) begin
      n_bad++;
      $display("FAIL abort_dly: got %0h want 0",
               {rom_index, en_delay, wr.wr_req, wr.wr_addr,
                wr.wr_data, busy, config_done});
    end
    tick(2);
    rom[0] = mk(OW, 8'hAA, 8'h55);
    auto_ack = 0;
    start = 1;
    tick(1);
    start = 0;
    k = 0;
    while (wr.wr_req !== 1 && k < 20) begin
      tick(1);
      k++;
    end
    n_cmp++;
    if (wr.wr_req !== 1 || wr.wr_addr !== 8'hAA) begin
      n_bad++;
      $display("FAIL abort_wr_pre: req=%b addr=%h want 1/aa",
               wr.wr_req, wr.wr_addr);
    end
    reset = 1;
    tick(1);
    reset = 0;
    n_cmp++;
    if ({rom_index, en_delay, wr.wr_req, wr.wr_addr,
         wr.wr_data, busy, config_done} !== '0) begin
      n_bad++;
      $display("FAIL abort_wr: got %0h want 0",
               {rom_index, en_delay, wr.wr_req, wr.wr_addr,
                wr.wr_data, busy, config_done});
    end
    tick(2);
  endtask

  task automatic test_spurious();
    int k;
    ack_man = 1;
    dd_man  = 1;
    tick(1);
    ack_man = 0;
    dd_man  = 0;
    tick(3);
    n_cmp++;
    if ({rom_index, en_delay, wr.wr_req, busy,
         config_done} !== '0) begin
      n_bad++;
      $display("FAIL spur_idle: got %0h want 0",
               {rom_index, en_delay, wr.wr_req, busy, config_done});
    end
    fill(ON);
    rom[0] = mk(OW, 8'hA5, 8'h3C);
    rom[1] = mk(OE, 0, 0);
    auto_ack = 0;
    start = 1;
    tick(1);
    start = 0;
    k = 0;
    while (wr.wr_req !== 1 && k < 20) begin
      tick(1);
      k++;
    end
    start  = 1;
    dd_man = 1;
    tick(1);
    start  = 0;
    dd_man = 0;
    tick(2);
    n_cmp++;
    if (wr.wr_req !== 1 || rom_index !== 0 || busy !== 1 ||
        {wr.wr_addr, wr.wr_data} !== 16'hA53C) begin
      n_bad++;
      $display("FAIL spur_busy: req=%b idx=%0d busy=%b ad=%h want 1/0/1/a53c",
               wr.wr_req, rom_index, busy,
               {wr.wr_addr, wr.wr_data});
    end
    ack_man = 1;
    tick(1);
    ack_man = 0;
    k = 0;
    while (config_done !== 1 && k < 20) begin
      tick(1);
      k++;
    end
    n_cmp++;
    if (config_done !== 1 || busy !== 0) begin
      n_bad++;
      $display("FAIL spur_finish: done=%b busy=%b want 1/0",
               config_done, busy);
    end
  endtask

  task automatic test_restart();
    fill(ON);
    rom[0] = mk(OW, 8'h77, 8'h88);
    rom[2] = mk(OW, 8'h99, 8'hAA);
    rom[3] = mk(OE, 0, 0);
    run_and_check("restart");
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < NUM; i++) begin
        int r;
        logic [1:0] op;
        r = $urandom_range(0, 99);
        op = (r < 40) ? OW : (r < 60) ? OD :
             (r < 88) ? ON : OE;
        rom[i] = mk(op, 8'($urandom),
                    (op == OD) ? 8'($urandom_range(0, 3))
                               : 8'($urandom));
      end
      run_and_check($sformatf("rand%0d", it));
    end
  endtask

  initial begin
    fill(ON);
    tick(3);
    reset = 0;
    tick(1);
    test_reset();
    test_basic_write();
    test_delay3();
    test_back_to_back();
    test_nop_full();
    test_reset_abort();
    test_spurious();
    test_restart();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
